// File: rtl/z80_bus_pkg.sv
// Shared types and strobe decode for the Z80 target-side bus responder.
package z80_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_DONE,
    ST_INTA
  } bus_state_e;

  typedef enum logic [2:0] {
    ACC_MEMRD,
    ACC_MEMWR,
    ACC_IORD,
    ACC_IOWR,
    ACC_INTA,
    ACC_NONE
  } acc_kind_e;

  localparam logic [7:0] Z80_IDLE_BYTE = 8'hFF;

  // Interrupt acknowledge wins over I/O so an M1+IORQ cycle is never forwarded.
  function automatic acc_kind_e decode_access(input logic m1_n, input logic mreq_n,
                                              input logic iorq_n, input logic rd_n,
                                              input logic wr_n, input logic rfsh_n);
    acc_kind_e k;
    if (!iorq_n && !m1_n)                 k = ACC_INTA;
    else if (!iorq_n && !rd_n)            k = ACC_IORD;
    else if (!iorq_n && !wr_n)            k = ACC_IOWR;
    else if (!mreq_n && !rd_n && rfsh_n)  k = ACC_MEMRD;
    else if (!mreq_n && !wr_n)            k = ACC_MEMWR;
    else                                  k = ACC_NONE;
    return k;
  endfunction

endpackage

// File: rtl/z80_irq_ctrl.sv
// Maskable interrupt pending flag; cleared when an acknowledge cycle ends.
module z80_irq_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic intack_done,
  output logic int_n
);

  logic pending;
  logic pending_nxt;

  // A new request arriving on the acknowledge release keeps the flag set.
  always_comb begin
    pending_nxt = irq | (pending & ~intack_done);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      int_n   <= 1'b1;
    end else begin
      pending <= pending_nxt;
      int_n   <= ~pending_nxt;
    end
  end

endmodule

// File: rtl/z80_bus_responder.sv
// Z80 bus target: forwards memory/I/O cycles to a req/ack backend, stretches
// the CPU with wait_n, and answers interrupt-acknowledge with a fixed vector.
module z80_bus_responder
  import z80_bus_pkg::*;
#(
  parameter int unsigned MIN_WAIT = 0,
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [7:0]  VECTOR   = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  input  logic [15:0] A,
  input  logic [7:0]  dout,
  output logic [7:0]  di,
  output logic        wait_n,
  output logic        int_n,
  input  logic        irq,
  output logic        bk_req,
  output logic        bk_we,
  output logic        bk_io,
  output logic [15:0] bk_addr,
  output logic [7:0]  bk_wdata,
  input  logic        bk_ack,
  input  logic [7:0]  bk_rdata,
  output logic        err
);

  localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);
  localparam logic [3:0] HOLD_LAST   = 4'(MIN_WAIT) - 4'd1;

  bus_state_e state;
  acc_kind_e  acc;
  logic       is_bus;
  logic       released;
  logic       intack_done;
  logic [9:0] to_cnt;
  logic [9:0] to_nxt;
  logic [3:0] hold_cnt;

  always_comb begin
    acc         = decode_access(m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n);
    is_bus      = acc inside {ACC_MEMRD, ACC_MEMWR, ACC_IORD, ACC_IOWR};
    released    = mreq_n & iorq_n & rd_n & wr_n;
    intack_done = (state == ST_INTA) & released;
    to_nxt      = (to_cnt == '1) ? to_cnt : to_cnt + 10'd1;
    // Combinational so the CPU sees the stretch in T2 of the very first cycle.
    wait_n      = ~(((state == ST_IDLE) & is_bus) | (state == ST_REQ) | (state == ST_HOLD));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      bk_req   <= 1'b0;
      bk_we    <= 1'b0;
      bk_io    <= 1'b0;
      bk_addr  <= '0;
      bk_wdata <= '0;
      di       <= Z80_IDLE_BYTE;
      err      <= 1'b0;
      to_cnt   <= '0;
      hold_cnt <= '0;
    end else begin
      err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (is_bus) begin
            bk_addr  <= A;
            bk_wdata <= dout;
            bk_we    <= (acc == ACC_MEMWR) || (acc == ACC_IOWR);
            bk_io    <= (acc == ACC_IORD) || (acc == ACC_IOWR);
            bk_req   <= 1'b1;
            to_cnt   <= '0;
            state    <= ST_REQ;
          end else if (acc == ACC_INTA) begin
            di    <= VECTOR;
            state <= ST_INTA;
          end
        end
        ST_REQ: begin
          if (released) begin
            bk_req <= 1'b0;
            state  <= ST_IDLE;
          end else if (bk_ack) begin
            bk_req   <= 1'b0;
            hold_cnt <= '0;
            if (!bk_we) di <= bk_rdata;
            state <= (MIN_WAIT > 0) ? ST_HOLD : ST_DONE;
          end else if (to_nxt == TIMEOUT_CNT) begin
            bk_req <= 1'b0;
            di     <= Z80_IDLE_BYTE;
            err    <= 1'b1;
            to_cnt <= to_nxt;
            state  <= ST_DONE;
          end else begin
            to_cnt <= to_nxt;
          end
        end
        ST_HOLD: begin
          if (released)                   state <= ST_IDLE;
          else if (hold_cnt == HOLD_LAST) state <= ST_DONE;
          else                            hold_cnt <= hold_cnt + 4'd1;
        end
        ST_DONE: begin
          if (released) state <= ST_IDLE;
        end
        ST_INTA: begin
          if (released) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  z80_irq_ctrl u_irq (
    .clk         (clk),
    .rst         (rst),
    .irq         (irq),
    .intack_done (intack_done),
    .int_n       (int_n)
  );

endmodule

// File: doc/z80_bus_responder.md
# z80_bus_responder

Target-side Z80 bus agent that sits on the bus driven by the registered-strobe Z80 core (M1/MREQ/IORQ/RD/WR, 16-bit address, 8-bit data). It decodes each bus cycle and forwards memory and I/O accesses to a simple synchronous backend request/acknowledge port. It stretches the Z80 cycle with `wait_n` until the backend answers, or a timeout fires, and returns read data on the CPU data-in bus. It also generates the maskable interrupt `int_n` and supplies the IM2/IM0 vector during interrupt-acknowledge cycles.

## Interface
Parameters:
- `MIN_WAIT`, default 0: extra wait cycles inserted after `bk_ack`, range 0..15.
- `TIMEOUT`, default 255: backend cycles allowed before abort, range 1..1023.
- `VECTOR`, default 8'hFF: byte returned in interrupt-acknowledge.

Ports (all synchronous to `clk`; one clock; reset is synchronous and active-high):
- `clk` in 1: system clock, the same clock as the CPU core.
- `rst` in 1: synchronous active-high reset.
- `m1_n`, `mreq_n`, `iorq_n`, `rd_n`, `wr_n`, `rfsh_n` in 1 each: CPU strobes.
- `A` in 16: CPU address.
- `dout` in 8: CPU write data.
- `di` out 8: CPU read data.
- `wait_n` out 1: CPU wait request.
- `int_n` out 1: CPU interrupt request.
- `irq` in 1: interrupt source; a one-cycle pulse sets pending.
- `bk_req` out 1: backend request.
- `bk_we` out 1: 1 = write.
- `bk_io` out 1: 1 = I/O space.
- `bk_addr` out 16: backend address.
- `bk_wdata` out 8: backend write data.
- `bk_ack` in 1: backend done, one-cycle pulse.
- `bk_rdata` in 8: read data, valid with `bk_ack`.
- `err` out 1: one-cycle pulse on timeout.

## Operation
- Access decode, evaluated in IDLE:
  - mem read: `mreq_n`=0, `rd_n`=0, `rfsh_n`=1.
  - mem write: `mreq_n`=0, `wr_n`=0.
  - io read: `iorq_n`=0, `rd_n`=0, `m1_n`=1.
  - io write: `iorq_n`=0, `wr_n`=0.
  - intack: `iorq_n`=0, `m1_n`=0.
  - Refresh (`rfsh_n`=0) is never forwarded.
- FSM states: IDLE, REQ, HOLD, DONE, INTA.
- IDLE → REQ on any mem or io access:
  - Latch `A`, `dout`, `bk_we`, `bk_io` into the backend registers.
  - Assert `bk_req` from the next cycle.
- REQ:
  - `bk_req`=1 until `bk_ack`.
  - On `bk_ack`, latch `bk_rdata` into `di` (reads only). Go to HOLD if `MIN_WAIT`>0, else DONE.
  - When the counter reaches `TIMEOUT` without ack: drop `bk_req`, set `di`=8'hFF, pulse `err`, go to DONE.
- HOLD: count `MIN_WAIT` cycles, then go to DONE.
- DONE: `wait_n`=1. Return to IDLE when all of `mreq_n`, `iorq_n`, `rd_n`, `wr_n` read 1.
- IDLE → INTA on intack:
  - Set `di`=`VECTOR`, no backend request, `wait_n` stays 1.
  - At strobe release, clear the pending interrupt and go to IDLE.
- Interrupt logic:
  - `irq`=1 sets pending; `int_n` = ~pending.
  - If `irq` and intack-release coincide, pending remains set.
- Aborted cycle: if strobes release while in REQ or HOLD (CPU aborted or reset), drop `bk_req` immediately and go to IDLE. A later `bk_ack` is ignored.

## Timing
- Reset values (in effect the cycle after `rst` is sampled high):
  - state IDLE.
  - `wait_n`=1, `int_n`=1, pending=0.
  - `bk_req`=0, `bk_we`=0, `bk_io`=0.
  - `bk_addr`=0, `bk_wdata`=0, `di`=8'hFF, `err`=0, counters 0.
- `wait_n` is combinational: `wait_n` = ~((IDLE & mem/io access decoded) | REQ | HOLD).
  - The CPU asserts strobes after the T1 edge and samples `wait_n` in T2, so the first-cycle assertion must be combinational.
  - This is the only combinational output path.
- `bk_req` rises one cycle after access detection. The backend registers are stable while `bk_req`=1.
- `bk_ack` in the same cycle that `bk_req` rises is legal and completes the access.
- `di` is registered:
  - It updates on the `bk_ack` edge, or at intack entry.
  - It holds until the next access, so it is stable when the CPU latches at T2 with `wait_n`=1.
- Zero-wait backend (ack the first `bk_req` cycle, `MIN_WAIT`=0): `wait_n` is low for exactly 2 cycles.
- The timeout counter is 10 bits, saturating, and cleared on entry to REQ.
- `err` fires exactly at REQ cycle `TIMEOUT`.

## Structure
- Shared package `z80_bus_pkg`:
  - FSM state enum.
  - Access-kind enum: MEMRD, MEMWR, IORD, IOWR, INTA, NONE.
  - Decode function from the strobes.
  - Constant `Z80_IDLE_BYTE` = 8'hFF.
- One sub-module `z80_irq_ctrl`: the pending flag, `int_n`, and clear-on-intack logic.
- The main FSM and datapath live in `z80_bus_responder`.

## Test plan
- Mem read at `A`=16'h1234, backend acks after 3 cycles with 8'hA5:
  - `bk_addr`=16'h1234, `bk_we`=0, `bk_io`=0.
  - `wait_n` low 4 cycles; CPU captures 8'hA5.
- IO write at `A`=16'h00FE, `dout`=8'h3C, ack after 1 cycle:
  - `bk_io`=1, `bk_we`=1, `bk_wdata`=8'h3C, single `bk_req` pulse burst.
- `TIMEOUT`=8, backend never acks:
  - `err` pulses once at REQ cycle 8, `wait_n` releases, CPU reads 8'hFF, FSM returns to IDLE.
- `irq` pulse with `VECTOR`=8'h20, CPU in IM2:
  - `int_n` goes low; intack returns 8'h20 with no `bk_req`.
  - `int_n` goes high after strobe release.
  - Second `irq` coinciding with that release leaves `int_n` low.
- Refresh cycle (`mreq_n`=0, `rfsh_n`=0): no `bk_req`, `wait_n` stays 1.
- `rst` asserted while in REQ:
  - Next cycle `bk_req`=0, `wait_n`=1, `di`=8'hFF.
  - Late `bk_ack` has no effect; the following read completes normally.
